truth_table_sweeper: RTL and testbench

- Synthesizable on-chip stimulus/capture engine for 4-input combinational lab functions.
- On `start`, drives all 16 input vectors `{a,b,c,d}` = 0000..1111 into the DUT, waits a settle time per vector, then samples the DUT output `q`.
- Builds a 16-bit truth table, compares it bit by bit against an expected table, and reports pass/fail plus mismatch information.
- Sits between the board controls/LEDs and the function-under-test, so a lab design can self-check in hardware without a simulator.

---
 rtl/truth_table_sweeper_if.sv | 30 +++
 rtl/truth_table_sweeper.sv | 116 +++++++++++
 tb/tb_truth_table_sweeper.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Purpose: bundles the sweeper's board-side controls/results and the stimulus/response wires to the function-under-test.
// Latency: none (wiring only).
// Backpressure: none; start is level-sampled by the sweeper, results hold until the next sweep.
interface truth_table_sweeper_if;
    logic        start;
    logic [15:0] expected;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        q;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        pass;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  mismatch_idx;

    // Board/lab side: issues start + expected table, and returns the function-under-test output q.
    modport master (
        output start, expected, q,
        input  a, b, c, d, busy, done, table_out, pass, mismatch_cnt, mismatch_idx
    );

    // Sweeper side.
    modport slave (
        input  start, expected, q,
        output a, b, c, d, busy, done, table_out, pass, mismatch_cnt, mismatch_idx
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Purpose: drives all 16 {a,b,c,d} vectors into a 4-input function, captures q, and grades it against an expected table.
// Latency: 16*(SETTLE_CYCLES+1) cycles from the accepted start edge to the done pulse.
// Backpressure: start is ignored while busy; a start held high re-launches on the edge after done.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  settle_cnt;
    logic [15:0] exp_q;
    logic [15:0] table_q;
    logic [4:0]  mm_cnt;
    logic [3:0]  mm_idx;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;

    logic        q_mismatch;
    logic [4:0]  mm_cnt_nxt;

    // Grade the current vector against the table latched at start; the count must reach 16 without wrapping.
    always_comb begin
        q_mismatch = (bus.q != exp_q[idx]);
        mm_cnt_nxt = mm_cnt + {4'd0, q_mismatch};
    end

    // Stimulus is the vector index itself, so a/b/c/d are straight register outputs.
    assign {bus.a, bus.b, bus.c, bus.d} = idx;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.table_out    = table_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = mm_cnt;
    assign bus.mismatch_idx = mm_idx;

    // Sweep sequencer: IDLE -> (SETTLE -> SAMPLE) x16 -> IDLE with a one-cycle done on the way out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            settle_cnt <= 8'd0;
            exp_q      <= 16'h0000;
            table_q    <= 16'h0000;
            mm_cnt     <= 5'd0;
            mm_idx     <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= SETTLE;
                        idx        <= 4'd0;
                        exp_q      <= bus.expected;
                        table_q    <= 16'h0000;
                        mm_cnt     <= 5'd0;
                        mm_idx     <= 4'd0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        settle_cnt <= SETTLE_RELOAD;
                    end
                end
                SETTLE: begin
                    // The extra SAMPLE cycle makes each vector last SETTLE_CYCLES+1 edges in total.
                    if (settle_cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    table_q[idx] <= bus.q;
                    mm_cnt       <= mm_cnt_nxt;
                    // Only the first mismatch is recorded; a zero count means no earlier mismatch.
                    if (q_mismatch && mm_cnt == 5'd0) begin
                        mm_idx <= idx;
                    end
                    if (idx == 4'd15) begin
                        state  <= IDLE;
                        idx    <= 4'd0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (mm_cnt_nxt == 5'd0);
                    end else begin
                        state      <= SETTLE;
                        idx        <= idx + 4'd1;
                        settle_cnt <= SETTLE_RELOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: scoreboard bench for truth_table_sweeper at SETTLE_CYCLES=4 and =1 with directed lab functions.
// Latency: expected done cycle is pushed with each launch and checked when done appears.
// Backpressure: restart-while-busy and held-start cases are exercised; stray done pulses are flagged.
module tb_truth_table_sweeper;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Edge counter; after posedge N settles, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweeper_if if4 ();
    truth_table_sweeper_if if1 ();

    truth_table_sweeper #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // Functions under test: dut4 selectable (0: a&b, 1: constant 1, 2: d), dut1 fixed a&b.
    int fmode4 = 0;
    assign if4.q = (fmode4 == 0) ? (if4.a & if4.b) : (fmode4 == 1) ? 1'b1 : if4.d;
    assign if1.q = if1.a & if1.b;

    typedef struct {
        int          done_cyc;
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  cnt;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb4[$];
    exp_t sb1[$];

    int checks = 0;
    int errors = 0;
    int e0_4   = -1000;
    int e0_1   = -1000;

    task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_res(string n, exp_t e, logic [15:0] tbl, logic p,
                           logic [4:0] cnt, logic [3:0] idx, logic bsy);
        cmp({n, "_done_cycle"}, cyc, e.done_cyc);
        cmp({n, "_table_out"}, tbl, e.tbl);
        cmp({n, "_pass"}, p, e.pass);
        cmp({n, "_mismatch_cnt"}, cnt, e.cnt);
        cmp({n, "_mismatch_idx"}, idx, e.idx);
        cmp({n, "_busy_at_done"}, bsy, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every done and checks the vector walk while a sweep runs.
    always @(negedge clk) begin
        exp_t e;
        int   diff;
        if (rst_n) begin
            if (if4.done) begin
                if (sb4.size() == 0) cmp("d4_unexpected_done", if4.done, 1'b0);
                else begin
                    e = sb4.pop_front();
                    chk_res("d4", e, if4.table_out, if4.pass, if4.mismatch_cnt, if4.mismatch_idx, if4.busy);
                end
            end
            if (if1.done) begin
                if (sb1.size() == 0) cmp("d1_unexpected_done", if1.done, 1'b0);
                else begin
                    e = sb1.pop_front();
                    chk_res("d1", e, if1.table_out, if1.pass, if1.mismatch_cnt, if1.mismatch_idx, if1.busy);
                end
            end
            diff = cyc - e0_4;
            if (diff >= 0 && diff < 80) begin
                cmp("d4_vector", {if4.a, if4.b, if4.c, if4.d}, diff / 5);
                cmp("d4_busy", if4.busy, 1'b1);
            end
            diff = cyc - e0_1;
            if (diff >= 0 && diff < 32) begin
                cmp("d1_vector", {if1.a, if1.b, if1.c, if1.d}, diff / 2);
                cmp("d1_busy", if1.busy, 1'b1);
            end
        end
    end

    task automatic launch4(int mode, logic [15:0] req, logic push,
                           logic [15:0] tbl, logic p, logic [4:0] cnt, logic [3:0] idx);
        exp_t e;
        @(posedge clk); #1;
        fmode4       = mode;
        if4.expected = req;
        if4.start    = 1'b1;
        e0_4         = cyc + 1;
        if (push) begin
            e = '{cyc + 1 + 80, tbl, p, cnt, idx};
            sb4.push_back(e);
        end
        @(posedge clk); #1;
        if4.start = 1'b0;
    endtask

    task automatic drain(int which);
        int n = 0;
        while (((which == 4) ? sb4.size() : sb1.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) cmp("drain_timeout_cycles", n, 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   first;
        if4.start    = 1'b0;
        if4.expected = 16'h0000;
        if1.start    = 1'b0;
        if1.expected = 16'h0000;

        #12;
        cmp("reset_d4_busy", if4.busy, 1'b0);
        cmp("reset_d4_outs", {if4.a, if4.b, if4.c, if4.d, if4.done, if4.pass}, 6'd0);
        cmp("reset_d4_table", if4.table_out, 16'h0000);
        cmp("reset_d1_busy", if1.busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // a&b against the exact table, against one wrong bit at vector 0, and at vector 11.
        launch4(0, 16'hF000, 1'b1, 16'hF000, 1'b1, 5'd0, 4'd0);
        drain(4);
        launch4(0, 16'hF001, 1'b1, 16'hF000, 1'b0, 5'd1, 4'd0);
        drain(4);
        launch4(0, 16'hF800, 1'b1, 16'hF000, 1'b0, 5'd1, 4'd11);
        drain(4);
        // q stuck at 1 against all-zero expectation: count must reach 16.
        launch4(1, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 5'd16, 4'd0);
        drain(4);

        // q=d, expected changed at vector 5 and a second start at vector 9 must both be ignored.
        launch4(2, 16'hAAAA, 1'b1, 16'hAAAA, 1'b1, 5'd0, 4'd0);
        repeat (25) @(posedge clk); #1;
        if4.expected = 16'h0000;
        repeat (20) @(posedge clk); #1;
        if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        drain(4);
        repeat (20) @(posedge clk);

        // Reset while vector 7 is driven: everything clears without a clock, no done follows.
        launch4(1, 16'h0000, 1'b0, 16'h0000, 1'b0, 5'd0, 4'd0);
        repeat (37) @(posedge clk); #1;
        cmp("d4_pre_reset_table", if4.table_out, 16'h007F);
        cmp("d4_pre_reset_cnt", if4.mismatch_cnt, 5'd7);
        rst_n = 1'b0;
        e0_4  = -1000;
        #1;
        cmp("abort_vector", {if4.a, if4.b, if4.c, if4.d}, 4'd0);
        cmp("abort_flags", {if4.busy, if4.done, if4.pass}, 3'd0);
        cmp("abort_table", if4.table_out, 16'h0000);
        cmp("abort_cnt", if4.mismatch_cnt, 5'd0);
        cmp("abort_idx", if4.mismatch_idx, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        launch4(0, 16'hF000, 1'b1, 16'hF000, 1'b1, 5'd0, 4'd0);
        drain(4);
        repeat (10) @(posedge clk);

        // S=1 with start held: back-to-back sweeps, second one using a table changed mid-first-sweep.
        @(posedge clk); #1;
        if1.expected = 16'hF000;
        if1.start    = 1'b1;
        first        = cyc + 1;
        e0_1         = first;
        e = '{first + 32, 16'hF000, 1'b1, 5'd0, 4'd0};
        sb1.push_back(e);
        e = '{first + 33 + 32, 16'hF000, 1'b0, 5'd3, 4'd12};
        sb1.push_back(e);
        @(posedge clk); #1;
        if1.expected = 16'h8000;
        repeat (32) @(posedge clk); #1;
        e0_1 = first + 33;
        @(posedge clk); #1;
        cmp("d1_restart_table_cleared", if1.table_out, 16'h0000);
        cmp("d1_restart_cnt_cleared", if1.mismatch_cnt, 5'd0);
        cmp("d1_restart_busy", if1.busy, 1'b1);
        if1.start = 1'b0;
        drain(1);
        repeat (40) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
